// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM state encoding and default widths for the ALU issue sequencer
package alu_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_NREGS  = 4;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b01;
  localparam logic [1:0] OP_LI   = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - NREGS x DATA_W register file, two operand read ports, debug read port, one sync write port
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  localparam int SEL_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEL_W-1:0]  ra_sel,
  output logic [DATA_W-1:0] ra_data,
  input  logic [SEL_W-1:0]  rb_sel,
  output logic [DATA_W-1:0] rb_data,
  input  logic [SEL_W-1:0]  dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [SEL_W-1:0]  wsel,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[wsel] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ra_data  = regs_q[ra_sel];
  assign rb_data  = regs_q[rb_sel];
  assign dbg_data = regs_q[dbg_sel];

endmodule

// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - one-at-a-time instruction sequencer: operand fetch, ALU drive, result write-back
module alu_issue_seq
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  localparam int SEL_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        instr_op,
  input  logic [SEL_W-1:0]  instr_rd,
  input  logic [SEL_W-1:0]  instr_ra,
  input  logic [SEL_W-1:0]  instr_rb,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic              alu_op,
  input  logic [DATA_W-1:0] alu_S,
  output logic              done,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [DATA_W-1:0] rd_data
);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [SEL_W-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              alu_op_q, alu_op_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] ra_data, rb_data;
  logic              wb_en;

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .ra_sel   (instr_ra),
    .ra_data  (ra_data),
    .rb_sel   (instr_rb),
    .rb_data  (rb_data),
    .dbg_sel  (rd_sel),
    .dbg_data (rd_data),
    .we       (wb_en),
    .wsel     (rd_q),
    .wdata    (result_q)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = 1'b0;
    result_d = result_q;
    wb_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          state_d = ST_EXEC;
          op_d    = instr_op;
          rd_d    = instr_rd;
          case (instr_op)
            OP_ADD: begin
              alu_a_d = ra_data;
              alu_b_d = rb_data;
            end
            OP_ADDI: begin
              alu_a_d = ra_data;
              alu_b_d = instr_imm;
            end
            OP_LI: begin
              alu_a_d = instr_imm;
              alu_b_d = '0;
            end
            default: begin
              alu_a_d = '0;
              alu_b_d = '0;
            end
          endcase
        end
      end
      ST_EXEC: begin
        result_d = alu_S;
        state_d  = ST_WB;
      end
      ST_WB: begin
        // NOP still walks through WB so done pulses, but never writes.
        wb_en   = (op_q != OP_NOP);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      rd_q     <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      result_q <= result_d;
    end
  end

  // Gated by reset so an aborted instruction shows neither done nor ready.
  assign instr_ready = (state_q == ST_IDLE) && !reset;
  assign done        = (state_q == ST_WB) && !reset;
  assign alu_A       = alu_a_q;
  assign alu_B       = alu_b_q;
  assign alu_op      = alu_op_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - randomized self-checking bench for alu_issue_seq with a behavioural ALU beside it
module tb_alu_issue_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] instr_op;
  logic [1:0] instr_rd, instr_ra, instr_rb;
  logic [7:0] instr_imm;
  logic [7:0] alu_A, alu_B, alu_S;
  logic       alu_op;
  logic       done;
  logic [1:0] rd_sel;
  logic [7:0] rd_data;

  int n_checks = 0;
  int n_errors = 0;
  int unsigned model_regs [4];

  always #5 clk = ~clk;

  assign alu_S = alu_op ? (alu_A - alu_B) : (alu_A + alu_B);

  alu_issue_seq dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_ra    (instr_ra),
    .instr_rb    (instr_rb),
    .instr_imm   (instr_imm),
    .alu_A       (alu_A),
    .alu_B       (alu_B),
    .alu_op      (alu_op),
    .alu_S       (alu_S),
    .done        (done),
    .rd_sel      (rd_sel),
    .rd_data     (rd_data)
  );

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      check_eq($sformatf("%s_r%0d", tag, i), rd_data, model_regs[i]);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) model_regs[i] = 0;
  endtask

  // Operands the ISA says the ALU should see, and the architectural effect.
  task automatic model_operands(input int op, input int ra, input int rb, input int imm,
                                output int unsigned a, output int unsigned b);
    case (op)
      0: begin a = model_regs[ra]; b = model_regs[rb]; end
      1: begin a = model_regs[ra]; b = imm; end
      2: begin a = imm; b = 0; end
      default: begin a = 0; b = 0; end
    endcase
  endtask

  task automatic model_commit(input int op, input int rd, input int unsigned a, input int unsigned b);
    if (op != 3) model_regs[rd] = (a + b) % 256;
  endtask

  task automatic drive_instr(input int op, input int rd, input int ra, input int rb, input int imm);
    instr_op  = 2'(op);
    instr_rd  = 2'(rd);
    instr_ra  = 2'(ra);
    instr_rb  = 2'(rb);
    instr_imm = 8'(imm);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the next IDLE cycle.
  task automatic send(input int op, input int rd, input int ra, input int rb, input int imm);
    int unsigned a, b, old_val;
    model_operands(op, ra, rb, imm, a, b);
    old_val = model_regs[rd];
    drive_instr(op, rd, ra, rb, imm);
    instr_valid = 1'b1;
    #1;
    check_eq("accept_ready", instr_ready, 1);
    @(negedge clk);
    instr_valid = 1'b1;
    drive_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 255));
    #1;
    check_eq("exec_done", done, 0);
    check_eq("exec_ready", instr_ready, 0);
    check_eq("exec_alu_A", alu_A, a);
    check_eq("exec_alu_B", alu_B, b);
    check_eq("exec_alu_op", alu_op, 0);
    @(negedge clk);
    rd_sel = 2'(rd);
    #1;
    check_eq("wb_done", done, 1);
    check_eq("wb_rd_old", rd_data, old_val);
    model_commit(op, rd, a, b);
    @(negedge clk);
    instr_valid = 1'b0;
    rd_sel = 2'(rd);
    #1;
    check_eq("idle_done", done, 0);
    check_eq("idle_ready", instr_ready, 1);
    check_eq("idle_rd_new", rd_data, model_regs[rd]);
  endtask

  initial begin
    int op4 [4], rd4 [4], ra4 [4], rb4 [4], imm4 [4];
    int idx, last_acc, cyc;
    int unsigned a, b;
    reset = 1'b1;
    instr_valid = 1'b0;
    drive_instr(0, 0, 0, 0, 0);
    rd_sel = 2'd0;
    model_clear();

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_ready", instr_ready, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_alu_A", alu_A, 0);
    check_eq("rst_alu_B", alu_B, 0);
    reset = 1'b0;
    #1;
    check_eq("post_rst_ready", instr_ready, 1);
    check_regs("rst");
    @(negedge clk);

    // LI/LI/ADD
    send(2, 1, 0, 0, 8'h25);
    send(2, 2, 0, 0, 8'h13);
    send(0, 3, 1, 2, 0);
    check_eq("add_r3", model_regs[3], 8'h38);
    check_regs("add");
    @(negedge clk);

    // wrap-around
    send(2, 0, 0, 0, 8'hF0);
    send(1, 0, 0, 0, 8'h20);
    check_eq("wrap_r0", model_regs[0], 8'h10);
    check_regs("wrap");
    @(negedge clk);

    // NOP leaves destination alone
    send(2, 2, 0, 0, 8'h7A);
    send(3, 2, 1, 1, $urandom_range(0, 255));
    check_eq("nop_r2", model_regs[2], 8'h7A);
    check_regs("nop");
    @(negedge clk);

    // back-to-back with instr_valid held high
    op4[0] = 2; rd4[0] = 0; ra4[0] = 0; rb4[0] = 0; imm4[0] = $urandom_range(0, 255);
    op4[1] = 2; rd4[1] = 3; ra4[1] = 0; rb4[1] = 0; imm4[1] = $urandom_range(0, 255);
    op4[2] = 0; rd4[2] = 1; ra4[2] = 0; rb4[2] = 3; imm4[2] = $urandom_range(0, 255);
    op4[3] = 1; rd4[3] = 2; ra4[3] = 1; rb4[3] = 2; imm4[3] = $urandom_range(0, 255);
    idx = 0; last_acc = -1; cyc = 0;
    while (idx < 4 && cyc < 40) begin
      drive_instr(op4[idx], rd4[idx], ra4[idx], rb4[idx], imm4[idx]);
      instr_valid = 1'b1;
      #1;
      check_eq("b2b_ready", instr_ready, (last_acc < 0 || cyc - last_acc >= 3) ? 1 : 0);
      if (instr_ready) begin
        if (last_acc >= 0) check_eq("b2b_spacing", cyc - last_acc, 3);
        last_acc = cyc;
        model_operands(op4[idx], ra4[idx], rb4[idx], imm4[idx], a, b);
        model_commit(op4[idx], rd4[idx], a, b);
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    instr_valid = 1'b0;
    check_eq("b2b_accepts", idx, 4);
    repeat (2) @(negedge clk);
    check_regs("b2b");
    @(negedge clk);

    // randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      send($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    check_regs("rand");
    @(negedge clk);

    // reset during EXEC aborts the instruction
    send(2, 1, 0, 0, 8'h44);
    drive_instr(1, 1, 1, 0, 8'h05);
    instr_valid = 1'b1;
    #1;
    check_eq("abort_accept_ready", instr_ready, 1);
    @(negedge clk);
    instr_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("abort_exec_done", done, 0);
    check_eq("abort_exec_ready", instr_ready, 0);
    @(negedge clk);
    #1;
    check_eq("abort_wb_done", done, 0);
    reset = 1'b0;
    #1;
    check_eq("abort_ready", instr_ready, 1);
    model_clear();
    check_regs("abort");
    @(negedge clk);
    #1;
    check_eq("abort_late_done", done, 0);
    check_eq("abort_alu_A", alu_A, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
